// File: rtl/configs_loader_pkg.sv
// Shared types and defaults for the configuration latch-bank loader.
// - state_e : loader FSM encoding
// - Def*    : default geometry and phase timing
// - max3    : helper used to size the shared phase down-counter
package configs_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitWord,
    StSetup,
    StEnable,
    StHold,
    StDone
  } state_e;

  localparam int unsigned DefWordW    = 32;
  localparam int unsigned DefNumWords = 26;
  localparam int unsigned DefSetupCyc = 1;
  localparam int unsigned DefPulseCyc = 2;
  localparam int unsigned DefHoldCyc  = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/configs_loader_if.sv
// Bundle of the loader's control, word-stream and latch-bank signals.
// - master : upstream/controller side (drives start, abort, word stream)
// - slave  : loader side (drives ready, latch data/enables and status)
interface configs_loader_if
  import configs_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = DefWordW,
  parameter int unsigned NUM_WORDS = DefNumWords
);

  logic                               io_start;
  logic                               io_abort;
  logic                               io_word_valid;
  logic                               io_word_ready;
  logic [WORD_W-1:0]                  io_word_data;
  logic [WORD_W-1:0]                  io_d_in;
  logic [NUM_WORDS-1:0]               io_configs_en;
  logic                               io_busy;
  logic                               io_done;
  logic [$clog2(NUM_WORDS+1)-1:0]     io_words_loaded;

  modport master (
    output io_start, io_abort, io_word_valid, io_word_data,
    input  io_word_ready, io_d_in, io_configs_en, io_busy, io_done, io_words_loaded
  );

  modport slave (
    input  io_start, io_abort, io_word_valid, io_word_data,
    output io_word_ready, io_d_in, io_configs_en, io_busy, io_done, io_words_loaded
  );

endinterface

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter with a zero flag; times the SETUP, ENABLE and HOLD phases.
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - load_i        : load load_val_i (takes priority over counting)
// - load_val_i    : value to load (phase length minus one)
// - zero_o        : counter is at zero, i.e. the current phase ends at the next edge
module cfg_phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/configs_loader.sv
// Write-side controller for a tile's configuration latch bank.
// Accepts NUM_WORDS words over valid/ready after a start pulse; for each word it drives
// io_d_in, waits SETUP_CYC, pulses one enable for PULSE_CYC, then holds data for HOLD_CYC.
// - clk    : clock
// - reset  : asynchronous active-low reset
// - bus_io : loader side of configs_loader_if (start/abort, word stream, latch outputs,
//            busy/done/words_loaded status)
module configs_loader
  import configs_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = DefWordW,
  parameter int unsigned NUM_WORDS = DefNumWords,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned PULSE_CYC = DefPulseCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
  input logic             clk,
  input logic             reset,
  configs_loader_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam int unsigned IdxW = $clog2(NUM_WORDS);
  localparam int unsigned WlW  = $clog2(NUM_WORDS + 1);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    d_in_q, d_in_d;
  logic [NUM_WORDS-1:0] en_q, en_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [WlW-1:0]       wl_q, wl_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_pend_q, abort_pend_d;

  logic                 tmr_load;
  logic [CntW-1:0]      tmr_val;
  logic                 tmr_zero;
  logic                 abort_now;

  cfg_phase_timer #(
    .Width (CntW)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Abort seen now or earlier in this word; only honoured at phase boundaries.
  assign abort_now = bus_io.io_abort | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    d_in_d       = d_in_q;
    en_d         = en_q;
    idx_d        = idx_q;
    wl_d         = wl_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.io_start) begin
          state_d      = StWaitWord;
          busy_d       = 1'b1;
          idx_d        = '0;
          wl_d         = '0;
          abort_pend_d = 1'b0;
        end
      end
      StWaitWord: begin
        if (bus_io.io_abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (bus_io.io_word_valid) begin
          d_in_d   = bus_io.io_word_data;
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (bus_io.io_abort) abort_pend_d = 1'b1;
        if (tmr_zero) begin
          if (abort_now) begin
            // Word never reached the latch: drop it without counting.
            state_d      = StIdle;
            busy_d       = 1'b0;
            abort_pend_d = 1'b0;
          end else begin
            state_d     = StEnable;
            en_d        = '0;
            en_d[idx_q] = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = CntW'(PULSE_CYC - 1);
          end
        end
      end
      StEnable: begin
        if (bus_io.io_abort) abort_pend_d = 1'b1;
        if (tmr_zero) begin
          state_d  = StHold;
          en_d     = '0;
          tmr_load = 1'b1;
          tmr_val  = CntW'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (bus_io.io_abort) abort_pend_d = 1'b1;
        if (tmr_zero) begin
          wl_d = wl_q + WlW'(1);
          // Index saturates at the last group so it can never wrap.
          if (idx_q != IdxW'(NUM_WORDS - 1)) idx_d = idx_q + IdxW'(1);
          if (abort_now) begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            abort_pend_d = 1'b0;
          end else if (idx_q == IdxW'(NUM_WORDS - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StWaitWord;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        en_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      d_in_q       <= '0;
      en_q         <= '0;
      idx_q        <= '0;
      wl_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_in_q       <= d_in_d;
      en_q         <= en_d;
      idx_q        <= idx_d;
      wl_q         <= wl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Latch-facing outputs come straight from flops so enables cannot glitch.
  assign bus_io.io_d_in         = d_in_q;
  assign bus_io.io_configs_en   = en_q;
  assign bus_io.io_busy         = busy_q;
  assign bus_io.io_done         = done_q;
  assign bus_io.io_words_loaded = wl_q;
  // Gated by abort so an aborted cycle can never complete a handshake.
  assign bus_io.io_word_ready   = (state_q == StWaitWord) && !bus_io.io_abort;

endmodule

// File: tb/tb_configs_loader.sv
// Directed bench for configs_loader: default DUT (26 words, 1/2/1) and a
// sweep DUT (4 words, 3/1/2). A per-cycle monitor checks enable/data invariants.
module tb_configs_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_r, abort_r, valid_r, sel_b;
  logic [31:0] data_r;
  bit          mon_on;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  configs_loader_if #(.WORD_W(32), .NUM_WORDS(26)) bus_a ();
  configs_loader_if #(.WORD_W(32), .NUM_WORDS(4))  bus_b ();

  assign bus_a.io_start      = start_r & ~sel_b;
  assign bus_a.io_abort      = abort_r & ~sel_b;
  assign bus_a.io_word_valid = valid_r & ~sel_b;
  assign bus_a.io_word_data  = data_r;
  assign bus_b.io_start      = start_r & sel_b;
  assign bus_b.io_abort      = abort_r & sel_b;
  assign bus_b.io_word_valid = valid_r & sel_b;
  assign bus_b.io_word_data  = data_r;

  configs_loader #(
    .WORD_W(32), .NUM_WORDS(26), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_a)
  );

  configs_loader #(
    .WORD_W(32), .NUM_WORDS(4), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
  ) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_b)
  );

  logic [31:0] obs_en, obs_d, obs_wl;
  logic        obs_rdy, obs_busy, obs_done;

  always_comb begin
    obs_en   = sel_b ? 32'(bus_b.io_configs_en)   : 32'(bus_a.io_configs_en);
    obs_d    = sel_b ? bus_b.io_d_in              : bus_a.io_d_in;
    obs_wl   = sel_b ? 32'(bus_b.io_words_loaded) : 32'(bus_a.io_words_loaded);
    obs_rdy  = sel_b ? bus_b.io_word_ready        : bus_a.io_word_ready;
    obs_busy = sel_b ? bus_b.io_busy              : bus_a.io_busy;
    obs_done = sel_b ? bus_b.io_done              : bus_a.io_done;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- invariant monitor (one slot per DUT) ----------------
  int unsigned mon_plen[2], mon_hold_left[2], mon_su_cnt[2], mon_rdy_cnt[2];
  bit          mon_su_arm[2], mon_rdy_arm[2];
  logic [31:0] mon_en_prev[2], mon_d_prev[2], mon_d_pulse[2];

  task automatic mon_clear();
    for (int i = 0; i < 2; i++) begin
      mon_plen[i] = 0; mon_hold_left[i] = 0; mon_su_cnt[i] = 0; mon_rdy_cnt[i] = 0;
      mon_su_arm[i] = 0; mon_rdy_arm[i] = 0;
      mon_en_prev[i] = '0; mon_d_prev[i] = '0; mon_d_pulse[i] = '0;
    end
  endtask

  task automatic mon_step(input int id, input logic [31:0] en, input logic [31:0] d,
                          input logic rdy, input logic vld, input logic busy,
                          input int unsigned s, input int unsigned p, input int unsigned h);
    check_eq("en_onehot0", 64'($onehot0(en)), 64'd1);
    if (mon_en_prev[id] != 0 && en != 0) begin
      check_eq("en_stable", en, mon_en_prev[id]);
      check_eq("d_stable_en", d, mon_d_prev[id]);
    end
    if (en != 0) begin
      mon_plen[id]++;
      mon_d_pulse[id] = d;
    end
    if (mon_en_prev[id] != 0 && en == 0) begin
      check_eq("pulse_len", mon_plen[id], p);
      mon_plen[id] = 0;
      mon_hold_left[id] = h;
    end
    if (mon_hold_left[id] > 0) begin
      check_eq("d_stable_hold", d, mon_d_pulse[id]);
      mon_hold_left[id]--;
    end
    if (mon_su_arm[id]) begin
      if (en != 0) begin
        check_eq("setup_len", mon_su_cnt[id], s);
        mon_su_arm[id] = 0;
      end else mon_su_cnt[id]++;
    end
    if (mon_rdy_arm[id]) begin
      if (rdy) begin
        check_eq("word_cycle", mon_rdy_cnt[id], s + p + h);
        mon_rdy_arm[id] = 0;
      end else mon_rdy_cnt[id]++;
    end
    if (!busy) begin
      mon_su_arm[id]  = 0;
      mon_rdy_arm[id] = 0;
    end
    if (vld && rdy) begin
      mon_su_arm[id] = 1;  mon_su_cnt[id] = 0;
      mon_rdy_arm[id] = 1; mon_rdy_cnt[id] = 0;
    end
    mon_en_prev[id] = en;
    mon_d_prev[id]  = d;
  endtask

  always @(negedge clk) begin
    if (reset && mon_on) begin
      mon_step(0, 32'(bus_a.io_configs_en), bus_a.io_d_in, bus_a.io_word_ready,
               bus_a.io_word_valid, bus_a.io_busy, 1, 2, 1);
      mon_step(1, 32'(bus_b.io_configs_en), bus_b.io_d_in, bus_b.io_word_ready,
               bus_b.io_word_valid, bus_b.io_busy, 3, 1, 2);
    end else begin
      mon_clear();
    end
  end

  // ---------------- frame driver ----------------
  // Cycle 0 is the start cycle; exp_done_at is the cycle index in which io_done is seen
  // (n*(1+S+P+H)+1 with valid always high). -1 means io_done must never pulse.
  task automatic run_frame(input bit use_b, input int n_words, input int p_cyc,
                           input logic [31:0] base, input int stall_word,
                           input int stall_len, input int abort_word, input int reset_word,
                           input int exp_done_at, input int exp_loaded);
    int          wi, cyc, stall_left, done_at, done_cnt, bad_d, bad_stall, stall_seen;
    int          n_ok, n_any;
    int          pulse_cnt[32];
    bit          aborted, hs, finished;
    logic [31:0] en;
    wi = 0; cyc = 0; stall_left = stall_len; done_at = -1; done_cnt = 0;
    bad_d = 0; bad_stall = 0; stall_seen = 0; aborted = 0; finished = 0;
    for (int i = 0; i < 32; i++) pulse_cnt[i] = 0;
    sel_b = use_b; data_r = base; valid_r = 1'b1; abort_r = 1'b0;
    step();
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      cyc++;
      en = obs_en;
      for (int i = 0; i < n_words; i++) begin
        if (en[i]) begin
          pulse_cnt[i]++;
          if (obs_d != base + 32'(i)) bad_d++;
        end
      end
      if (obs_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (!valid_r && obs_rdy) begin
        stall_seen++;
        if (en != 0 || obs_d != base + 32'(wi - 1)) bad_stall++;
        stall_left--;
      end
      if (reset_word >= 0 && en[reset_word]) begin
        #2;
        mon_on = 0;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_en", obs_en, 32'd0);
        check_eq("rst_mid_d_in", obs_d, 32'd0);
        check_eq("rst_mid_busy", obs_busy, 1'b0);
        check_eq("rst_mid_wl", obs_wl, 32'd0);
        check_eq("rst_mid_ready", obs_rdy, 1'b0);
        start_r = 1'b0; valid_r = 1'b0; abort_r = 1'b0;
        return;
      end
      if (!obs_busy) begin
        finished = 1;
        break;
      end
      hs = valid_r && obs_rdy;
      step();
      abort_r = 1'b0;
      if (hs) begin
        wi++;
        data_r = base + 32'(wi);
      end
      if (abort_word >= 0 && !aborted && en[abort_word]) begin
        abort_r = 1'b1;
        aborted = 1;
      end
      valid_r = !(wi == stall_word && stall_left > 0);
    end
    valid_r = 1'b0;
    check_eq("frame_finished", finished, 1'b1);
    check_eq("done_at", done_at, exp_done_at);
    check_eq("done_pulses", done_cnt, (exp_done_at < 0) ? 0 : 1);
    check_eq("words_loaded", obs_wl, exp_loaded);
    n_ok = 0; n_any = 0;
    for (int i = 0; i < n_words; i++) begin
      if (pulse_cnt[i] == p_cyc) n_ok++;
      if (pulse_cnt[i] != 0) n_any++;
    end
    check_eq("full_pulses", n_ok, exp_loaded);
    check_eq("pulsed_words", n_any, exp_loaded);
    check_eq("d_in_vs_word", bad_d, 0);
    if (stall_len > 0) begin
      check_eq("stall_cycles", stall_seen, stall_len);
      check_eq("stall_held", bad_stall, 0);
    end
    check_eq("busy_end", obs_busy, 1'b0);
    check_eq("ready_end", obs_rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mon_on = 0; start_r = 1'b0; abort_r = 1'b0; valid_r = 1'b0;
    sel_b = 1'b0; data_r = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_d_in", bus_a.io_d_in, 32'd0);
    check_eq("rst_en", 32'(bus_a.io_configs_en), 32'd0);
    check_eq("rst_busy", bus_a.io_busy, 1'b0);
    check_eq("rst_done", bus_a.io_done, 1'b0);
    check_eq("rst_wl", 32'(bus_a.io_words_loaded), 32'd0);
    check_eq("rst_ready", bus_a.io_word_ready, 1'b0);
    check_eq("rst_en_b", 32'(bus_b.io_configs_en), 32'd0);
    step();
    reset = 1'b1;
    mon_on = 1;
    step();

    // Full frame, valid always high: 26*(1+4)+1 = 131.
    run_frame(0, 26, 2, 32'hC0DE_0000, -1, 0, -1, -1, 131, 26);
    // Seven stalled cycles before word 5 push done out by 7.
    run_frame(0, 26, 2, 32'hC0DE_0000, 5, 7, -1, -1, 138, 26);
    // Abort during ENABLE of word 3: words 0..3 complete, no done.
    run_frame(0, 26, 2, 32'hC0DE_0000, -1, 0, 3, -1, -1, 4);

    // Start re-pulsed mid-frame is ignored; abort in WAIT_WORD exits at once.
    sel_b = 1'b0; valid_r = 1'b0; data_r = 32'h1234_5678;
    step(); start_r = 1'b1;
    step(); start_r = 1'b0;
    @(negedge clk);
    check_eq("mf_ready_wait", obs_rdy, 1'b1);
    check_eq("mf_busy", obs_busy, 1'b1);
    step(); valid_r = 1'b1;
    step(); valid_r = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check_eq("mf_wl_one", obs_wl, 32'd1);
    check_eq("mf_ready_back", obs_rdy, 1'b1);
    step(); start_r = 1'b1;
    step(); start_r = 1'b0;
    @(negedge clk);
    check_eq("mf_restart_busy", obs_busy, 1'b1);
    check_eq("mf_restart_wl", obs_wl, 32'd1);
    check_eq("mf_restart_ready", obs_rdy, 1'b1);
    step(); abort_r = 1'b1; valid_r = 1'b1; data_r = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("mf_abort_ready_gated", obs_rdy, 1'b0);
    step(); abort_r = 1'b0; valid_r = 1'b0;
    @(negedge clk);
    check_eq("mf_abort_busy", obs_busy, 1'b0);
    check_eq("mf_abort_ready", obs_rdy, 1'b0);
    check_eq("mf_abort_d_in", obs_d, 32'h1234_5678);
    check_eq("mf_abort_wl", obs_wl, 32'd1);
    check_eq("mf_abort_done", obs_done, 1'b0);

    // Async reset during en[10], then a fresh frame from index 0.
    run_frame(0, 26, 2, 32'hC0DE_0000, -1, 0, -1, 10, -1, 0);
    #2;
    reset = 1'b1;
    step();
    mon_on = 1;
    run_frame(0, 26, 2, 32'hA5A5_0000, -1, 0, -1, -1, 131, 26);

    // Sweep DUT, S/P/H = 3/1/2, 4 words: 4*(1+6)+1 = 29.
    run_frame(1, 4, 1, 32'hB000_0000, -1, 0, -1, -1, 29, 4);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
